// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding
// and the packed bundle of per-register hold/flush/redirect controls.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    PSC_RUN      = 2'd0,
    PSC_MEM_WAIT = 2'd1,
    PSC_ERR      = 2'd2
  } psc_state_e;

  // Field order doubles as the bit order of the constant patterns below.
  typedef struct packed {
    logic stop_pc;
    logic stop_if_id;
    logic stop_id_ex;
    logic stop_ex_mem;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_mem_wb;
    logic pc_redirect;
  } psc_ctrl_t;

  // Nothing moves.
  localparam psc_ctrl_t PSC_CTRL_IDLE     = 8'b0000_0000;
  // Whole front end frozen behind MEM; MEM/WB gets a bubble so the stalled
  // instruction does not write the register file repeatedly.
  localparam psc_ctrl_t PSC_CTRL_FREEZE   = 8'b1111_0010;
  // Load-use: hold PC and IF/ID, inject one bubble into ID/EX.
  localparam psc_ctrl_t PSC_CTRL_LOAD_USE = 8'b1100_0100;
  // Taken branch/jump: squash the two younger instructions, steer the PC.
  localparam psc_ctrl_t PSC_CTRL_REDIRECT = 8'b0000_1101;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear first, otherwise increment unless already all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Arbitrates the
// MEM-stage data-memory wait, the EX-stage redirect and the ID-stage
// load-use hazard, times out hung memory accesses, and counts stalls.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             load_hazard_ID,
  input  logic             redirect_EX,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ack,
  input  logic             perf_clr,
  output logic             stop_PC,
  output logic             stop_IF_ID,
  output logic             stop_ID_EX,
  output logic             stop_EX_MEM,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_MEM_WB,
  output logic             pc_redirect,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] load_stall_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT_CYC);

  psc_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              bus_err_q, bus_err_d;
  psc_ctrl_t         ctrl;
  logic              load_bubble;

  // Next-state, wait-counter and control decode; reset forces every output low.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    bus_err_d   = bus_err_q;
    ctrl        = PSC_CTRL_IDLE;
    load_bubble = 1'b0;

    unique case (state_q)
      PSC_RUN: begin
        if (dmem_req_MEM && !dmem_ack) begin
          // Memory not ready: freeze and start timing the wait. The first
          // frozen cycle already counts as one waited cycle.
          ctrl       = PSC_CTRL_FREEZE;
          state_d    = PSC_MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end else if (redirect_EX) begin
          // The ID instruction is squashed, so its load-use hazard is moot.
          ctrl = PSC_CTRL_REDIRECT;
        end else if (load_hazard_ID) begin
          ctrl        = PSC_CTRL_LOAD_USE;
          load_bubble = 1'b1;
        end
      end

      PSC_MEM_WAIT: begin
        if (dmem_ack) begin
          // Release cycle: everything moves. Any redirect/load-use from the
          // frozen instructions re-asserts next cycle and is handled in RUN.
          state_d    = PSC_RUN;
          wait_cnt_d = '0;
        end else begin
          ctrl = PSC_CTRL_FREEZE;
          if (wait_cnt_q >= WAIT_LAST) begin
            wait_cnt_d = WAIT_MAX;
            bus_err_d  = 1'b1;
            state_d    = PSC_ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
          end
        end
      end

      PSC_ERR: begin
        // Terminal: pipeline stays frozen until reset.
        ctrl = PSC_CTRL_FREEZE;
      end

      default: begin
        state_d = PSC_RUN;
      end
    endcase

    if (cpu_rst) begin
      ctrl        = PSC_CTRL_IDLE;
      load_bubble = 1'b0;
    end
  end

  // State, wait counter and sticky bus error register.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q    <= PSC_RUN;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign stop_PC      = ctrl.stop_pc;
  assign stop_IF_ID   = ctrl.stop_if_id;
  assign stop_ID_EX   = ctrl.stop_id_ex;
  assign stop_EX_MEM  = ctrl.stop_ex_mem;
  assign flush_IF_ID  = ctrl.flush_if_id;
  assign flush_ID_EX  = ctrl.flush_id_ex;
  assign flush_MEM_WB = ctrl.flush_mem_wb;
  assign pc_redirect  = ctrl.pc_redirect;
  assign bus_err      = bus_err_q & ~cpu_rst;

  // Performance counters: index 0 counts PC-stall cycles, index 1 counts
  // load-use bubbles.
  logic [1:0]       perf_inc;
  logic [CNT_W-1:0] perf_val [2];

  assign perf_inc = {load_bubble, ctrl.stop_pc};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
      sat_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk (cpu_clk),
        .rst (cpu_rst),
        .inc (perf_inc[gi]),
        .clr (perf_clr),
        .cnt (perf_val[gi])
      );
    end
  endgenerate

  assign stall_cnt      = perf_val[0];
  assign load_stall_cnt = perf_val[1];

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (TIMEOUT_CYC=4, CNT_W=3).
// Inputs change 1ns after the rising edge; outputs are checked on the
// falling edge.
module tb_pipeline_stall_ctrl;

  localparam int TO = 4;
  localparam int CW = 3;

  // Bit order: stop_PC stop_IF_ID stop_ID_EX stop_EX_MEM flush_IF_ID
  //            flush_ID_EX flush_MEM_WB pc_redirect bus_err
  localparam logic [8:0] C_IDLE   = 9'b0000_0000_0;
  localparam logic [8:0] C_FREEZE = 9'b1111_0010_0;
  localparam logic [8:0] C_LOAD   = 9'b1100_0100_0;
  localparam logic [8:0] C_REDIR  = 9'b0000_1101_0;
  localparam logic [8:0] C_ERR    = 9'b1111_0010_1;

  logic          cpu_clk, cpu_rst;
  logic          load_hazard_ID, redirect_EX, dmem_req_MEM, dmem_ack, perf_clr;
  logic          stop_PC, stop_IF_ID, stop_ID_EX, stop_EX_MEM;
  logic          flush_IF_ID, flush_ID_EX, flush_MEM_WB, pc_redirect, bus_err;
  logic [CW-1:0] stall_cnt, load_stall_cnt;
  logic [8:0]    ctl;

  int checks = 0;
  int errors = 0;

  pipeline_stall_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .cpu_clk        (cpu_clk),
    .cpu_rst        (cpu_rst),
    .load_hazard_ID (load_hazard_ID),
    .redirect_EX    (redirect_EX),
    .dmem_req_MEM   (dmem_req_MEM),
    .dmem_ack       (dmem_ack),
    .perf_clr       (perf_clr),
    .stop_PC        (stop_PC),
    .stop_IF_ID     (stop_IF_ID),
    .stop_ID_EX     (stop_ID_EX),
    .stop_EX_MEM    (stop_EX_MEM),
    .flush_IF_ID    (flush_IF_ID),
    .flush_ID_EX    (flush_ID_EX),
    .flush_MEM_WB   (flush_MEM_WB),
    .pc_redirect    (pc_redirect),
    .bus_err        (bus_err),
    .stall_cnt      (stall_cnt),
    .load_stall_cnt (load_stall_cnt)
  );

  assign ctl = {stop_PC, stop_IF_ID, stop_ID_EX, stop_EX_MEM,
                flush_IF_ID, flush_ID_EX, flush_MEM_WB, pc_redirect, bus_err};

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_hazard_ID = 0; redirect_EX = 0; dmem_req_MEM = 0; dmem_ack = 0; perf_clr = 0;
  endtask

  task automatic clear_perf();
    idle_inputs();
    perf_clr = 1;
    tick();
    perf_clr = 0;
  endtask

  task automatic test_reset();
    cpu_rst = 1;
    load_hazard_ID = 1; redirect_EX = 1; dmem_req_MEM = 1; dmem_ack = 1; perf_clr = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge cpu_clk);
      checks++;
      if (ctl !== C_IDLE) begin
        errors++; $display("FAIL reset_ctl[%0d]: got %b expected %b", i, ctl, C_IDLE);
      end
    end
    checks++;
    if (stall_cnt !== 0 || load_stall_cnt !== 0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, load_stall_cnt);
    end
    tick();
    cpu_rst = 0;
    idle_inputs();
    $display("reset: done");
  endtask

  task automatic test_load_use();
    clear_perf();
    load_hazard_ID = 1;
    @(negedge cpu_clk);
    checks++;
    if (ctl !== C_LOAD) begin
      errors++; $display("FAIL load_use_ctl: got %b expected %b", ctl, C_LOAD);
    end
    tick();
    load_hazard_ID = 0;
    @(negedge cpu_clk);
    checks++;
    if (ctl !== C_IDLE) begin
      errors++; $display("FAIL load_use_after: got %b expected %b", ctl, C_IDLE);
    end
    checks++;
    if (load_stall_cnt !== 1 || stall_cnt !== 1) begin
      errors++; $display("FAIL load_use_cnt: got %0d/%0d expected 1/1", load_stall_cnt, stall_cnt);
    end
    tick();
    $display("load_use: done");
  endtask

  task automatic test_redirect_load();
    clear_perf();
    redirect_EX = 1; load_hazard_ID = 1;
    @(negedge cpu_clk);
    checks++;
    if (ctl !== C_REDIR) begin
      errors++; $display("FAIL redirect_load_ctl: got %b expected %b", ctl, C_REDIR);
    end
    tick();
    idle_inputs();
    @(negedge cpu_clk);
    checks++;
    if (load_stall_cnt !== 0 || stall_cnt !== 0) begin
      errors++; $display("FAIL redirect_load_cnt: got %0d/%0d expected 0/0", load_stall_cnt, stall_cnt);
    end
    tick();
    $display("redirect_load: done");
  endtask

  task automatic test_zero_wait();
    dmem_req_MEM = 1; dmem_ack = 1; load_hazard_ID = 1;
    @(negedge cpu_clk);
    checks++;
    if (ctl !== C_LOAD) begin
      errors++; $display("FAIL zero_wait_ctl: got %b expected %b", ctl, C_LOAD);
    end
    tick();
    idle_inputs();
    $display("zero_wait: done");
  endtask

  task automatic test_mem_wait();
    clear_perf();
    dmem_req_MEM = 1; redirect_EX = 1; load_hazard_ID = 1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge cpu_clk);
      checks++;
      if (ctl !== C_FREEZE) begin
        errors++; $display("FAIL mem_wait_freeze[%0d]: got %b expected %b", i, ctl, C_FREEZE);
      end
      tick();
    end
    dmem_ack = 1;
    @(negedge cpu_clk);
    checks++;
    if (ctl !== C_IDLE) begin
      errors++; $display("FAIL mem_wait_release: got %b expected %b", ctl, C_IDLE);
    end
    tick();
    dmem_req_MEM = 0; dmem_ack = 0; load_hazard_ID = 0;
    @(negedge cpu_clk);
    checks++;
    if (ctl !== C_REDIR) begin
      errors++; $display("FAIL mem_wait_deferred_redirect: got %b expected %b", ctl, C_REDIR);
    end
    checks++;
    if (stall_cnt !== 3 || load_stall_cnt !== 0) begin
      errors++; $display("FAIL mem_wait_cnt: got %0d/%0d expected 3/0", stall_cnt, load_stall_cnt);
    end
    tick();
    idle_inputs();
    @(negedge cpu_clk);
    checks++;
    if (ctl !== C_IDLE) begin
      errors++; $display("FAIL mem_wait_idle: got %b expected %b", ctl, C_IDLE);
    end
    tick();
    $display("mem_wait: done");
  endtask

  task automatic test_timeout();
    clear_perf();
    dmem_req_MEM = 1;
    for (int i = 0; i < TO; i++) begin
      @(negedge cpu_clk);
      checks++;
      if (ctl !== C_FREEZE) begin
        errors++; $display("FAIL timeout_wait[%0d]: got %b expected %b", i, ctl, C_FREEZE);
      end
      tick();
    end
    @(negedge cpu_clk);
    checks++;
    if (ctl !== C_ERR) begin
      errors++; $display("FAIL timeout_err: got %b expected %b", ctl, C_ERR);
    end
    // Late ack and new hazards must not leave ERR.
    tick();
    dmem_req_MEM = 0; dmem_ack = 1; redirect_EX = 1; load_hazard_ID = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge cpu_clk);
      checks++;
      if (ctl !== C_ERR) begin
        errors++; $display("FAIL timeout_sticky[%0d]: got %b expected %b", i, ctl, C_ERR);
      end
      tick();
    end
    tick(); tick(); tick();
    @(negedge cpu_clk);
    checks++;
    if (stall_cnt !== 7) begin
      errors++; $display("FAIL stall_cnt_saturate: got %0d expected 7", stall_cnt);
    end
    idle_inputs();
    tick();
    cpu_rst = 1;
    @(negedge cpu_clk);
    checks++;
    if (ctl !== C_IDLE) begin
      errors++; $display("FAIL timeout_reset_ctl: got %b expected %b", ctl, C_IDLE);
    end
    tick();
    cpu_rst = 0;
    load_hazard_ID = 1;
    @(negedge cpu_clk);
    checks++;
    if (ctl !== C_LOAD) begin
      errors++; $display("FAIL timeout_back_to_run: got %b expected %b", ctl, C_LOAD);
    end
    checks++;
    if (stall_cnt !== 0) begin
      errors++; $display("FAIL timeout_reset_cnt: got %0d expected 0", stall_cnt);
    end
    tick();
    idle_inputs();
    $display("timeout: done");
  endtask

  task automatic test_saturation();
    clear_perf();
    load_hazard_ID = 1;
    for (int i = 0; i < 10; i++) tick();
    @(negedge cpu_clk);
    checks++;
    if (load_stall_cnt !== 7) begin
      errors++; $display("FAIL load_cnt_saturate: got %0d expected 7", load_stall_cnt);
    end
    tick();
    perf_clr = 1;
    @(negedge cpu_clk);
    checks++;
    if (ctl !== C_LOAD) begin
      errors++; $display("FAIL clr_with_hazard_ctl: got %b expected %b", ctl, C_LOAD);
    end
    tick();
    idle_inputs();
    @(negedge cpu_clk);
    checks++;
    if (load_stall_cnt !== 0 || stall_cnt !== 0) begin
      errors++; $display("FAIL clr_wins: got %0d/%0d expected 0/0", load_stall_cnt, stall_cnt);
    end
    tick();
    $display("saturation: done");
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect_load();
    test_zero_wait();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
